inst_buffer: RTL and testbench

- Instruction buffer. Receiving end of the predecode-to-instbuffer interface (en / num / inst / fsqIdx).
- Accepts up to BLOCK_INST_SIZE predecoded instructions per cycle into a circular FIFO.
- Hands up to FETCH_WIDTH instructions per cycle, in order, to decode, each tagged with its fsqIdx.
- Decouples fetch-block granularity from decode width. Gives backpressure to predecode through `full`.

---
 rtl/inst_buffer_if.sv | 27 ++
 rtl/inst_buffer.sv | 116 +++++++++++
 tb/tb_inst_buffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_if.sv
// Predecode-to-instbuffer write bus plus the instbuffer-to-decode read bus.
// Master drives writes and out_ready; slave (the buffer) returns full and the output slots.
interface inst_buffer_if #(
    parameter int BLOCK_INST_SIZE = 8,
    parameter int FETCH_WIDTH     = 4,
    parameter int FSQ_WIDTH       = 4
);
    logic [BLOCK_INST_SIZE-1:0]          in_en;
    logic [$clog2(BLOCK_INST_SIZE)-1:0]  in_num;
    logic [BLOCK_INST_SIZE*32-1:0]       in_inst;
    logic [FSQ_WIDTH-1:0]                in_fsqIdx;
    logic                                full;
    logic [FETCH_WIDTH-1:0]              out_valid;
    logic [FETCH_WIDTH*32-1:0]           out_inst;
    logic [FETCH_WIDTH*FSQ_WIDTH-1:0]    out_fsqIdx;
    logic                                out_ready;

    modport master (
        output in_en, in_num, in_inst, in_fsqIdx, out_ready,
        input  full, out_valid, out_inst, out_fsqIdx
    );

    modport slave (
        input  in_en, in_num, in_inst, in_fsqIdx, out_ready,
        output full, out_valid, out_inst, out_fsqIdx
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction FIFO: up to BLOCK_INST_SIZE writes and FETCH_WIDTH reads per cycle, 1-cycle
// write-to-read latency; registered full holds predecode whenever a whole block might not fit.
module inst_buffer #(
    parameter int BLOCK_INST_SIZE = 8,
    parameter int FETCH_WIDTH     = 4,
    parameter int DEPTH           = 32,
    parameter int FSQ_WIDTH       = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    inst_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef logic [PW:0] ptr_t;

    typedef struct packed {
        logic [31:0]          inst;
        logic [FSQ_WIDTH-1:0] fsq_idx;
    } entry_t;

    localparam ptr_t              FETCH_P   = ptr_t'(FETCH_WIDTH);
    localparam ptr_t              DEPTH_P   = ptr_t'(DEPTH);
    localparam logic [PW+1:0]     FULL_THR  = (PW+2)'(DEPTH - BLOCK_INST_SIZE);
    localparam logic [PW+1:0]     DEPTH_W   = (PW+2)'(DEPTH);
    localparam logic [BLOCK_INST_SIZE-1:0] EN_ONE = {{(BLOCK_INST_SIZE-1){1'b0}}, 1'b1};

    entry_t        mem [DEPTH];
    ptr_t          head;
    ptr_t          tail;
    ptr_t          count;
    ptr_t          wr_num;
    ptr_t          rd_num;
    ptr_t          wr_eff;
    ptr_t          rd_eff;
    logic          full_q;
    logic          wr_acc;
    logic [PW+1:0] count_next;

    logic [FETCH_WIDTH-1:0]           valid_c;
    logic [FETCH_WIDTH*32-1:0]        inst_c;
    logic [FETCH_WIDTH*FSQ_WIDTH-1:0] fsq_c;

    // The wrap bit makes tail-head range over 0..DEPTH without ambiguity.
    assign count = tail - head;

    always_comb begin
        wr_num = '0;
        for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
            wr_num = wr_num + ptr_t'(bus.in_en[i]);
        end
    end

    assign wr_acc     = (|bus.in_en) && !full_q && !flush;
    assign rd_num     = (count > FETCH_P) ? FETCH_P : count;
    assign wr_eff     = wr_acc ? wr_num : '0;
    assign rd_eff     = (bus.out_ready && !flush) ? rd_num : '0;
    assign count_next = {1'b0, count} + {1'b0, wr_eff} - {1'b0, rd_eff};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            full_q <= 1'b0;
        end else if (flush) begin
            head   <= tail;
            full_q <= 1'b0;
        end else begin
            head   <= head + rd_eff;
            tail   <= tail + wr_eff;
            full_q <= (count_next > FULL_THR);
        end
    end

    // Storage needs no reset: nothing is visible until the pointers say so.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
            if (wr_acc && bus.in_en[i]) begin
                mem[tail[PW-1:0] + PW'(i)] <= '{inst:    bus.in_inst[i*32 +: 32],
                                                fsq_idx: bus.in_fsqIdx};
            end
        end
    end

    // Invalid slots are driven to zero so stale storage never leaks onto the bus.
    always_comb begin
        valid_c = '0;
        inst_c  = '0;
        fsq_c   = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if ((ptr_t'(j) < count) && !flush) begin
                valid_c[j]                         = 1'b1;
                inst_c[j*32 +: 32]                 = mem[head[PW-1:0] + PW'(j)].inst;
                fsq_c[j*FSQ_WIDTH +: FSQ_WIDTH]    = mem[head[PW-1:0] + PW'(j)].fsq_idx;
            end
        end
    end

    assign bus.full       = full_q;
    assign bus.out_valid  = valid_c;
    assign bus.out_inst   = inst_c;
    assign bus.out_fsqIdx = fsq_c;

    a_in_en_thermo: assert property (@(posedge clk) disable iff (rst)
        ((bus.in_en & (bus.in_en + EN_ONE)) == '0));

    a_in_num_match: assert property (@(posedge clk) disable iff (rst)
        ((bus.in_en == '0) || (ptr_t'(bus.in_num) == wr_num - ptr_t'(1))));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (!wr_acc || (count_next <= DEPTH_W)));

    a_head_le_tail: assert property (@(posedge clk) disable iff (rst)
        (count <= DEPTH_P));
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: fill/drain ordering, full threshold, wrap, flush, async reset.
module tb_inst_buffer;
    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   errors;

    inst_buffer_if #(.BLOCK_INST_SIZE(8), .FETCH_WIDTH(4), .FSQ_WIDTH(4)) bus ();

    inst_buffer #(
        .BLOCK_INST_SIZE(8),
        .FETCH_WIDTH    (4),
        .DEPTH          (32),
        .FSQ_WIDTH      (4)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present n instructions base+0..base+n-1 with one fsq tag, plus read/flush controls.
    task automatic drive(input int n, input logic [3:0] fsq, input logic [31:0] base,
                         input logic rdy, input logic fl);
        logic [7:0] en;
        en = '0;
        for (int i = 0; i < n; i++) en[i] = 1'b1;
        bus.in_en     = en;
        bus.in_num    = (n == 0) ? 3'd0 : 3'(n - 1);
        for (int i = 0; i < 8; i++)
            bus.in_inst[i*32 +: 32] = (i < n) ? base + 32'(i) : 32'h0;
        bus.in_fsqIdx = fsq;
        bus.out_ready = rdy;
        flush         = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slots(input string tag, input int nv, input logic [31:0] base,
                             input logic [3:0] fsq);
        logic [3:0] vexp;
        vexp = '0;
        for (int j = 0; j < nv; j++) vexp[j] = 1'b1;
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(vexp));
        for (int j = 0; j < nv; j++) begin
            check($sformatf("%s_inst%0d", tag, j), 64'(bus.out_inst[j*32 +: 32]), 64'(base + 32'(j)));
            check($sformatf("%s_fsq%0d", tag, j), 64'(bus.out_fsqIdx[j*4 +: 4]), 64'(fsq));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("rst_valid", 64'(bus.out_valid), 64'h0);
        check("rst_full", 64'(bus.full), 64'h0);
        #9;
        rst = 1'b0;
        tick();
        check("idle_valid", 64'(bus.out_valid), 64'h0);
        check("idle_full", 64'(bus.full), 64'h0);

        // Single partial block, then one read drains it.
        drive(3, 4'h3, 32'hA0, 1'b0, 1'b0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk_slots("one", 3, 32'hA0, 4'h3);
        drive(0, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("one_drained", 64'(bus.out_valid), 64'h0);

        // Two full blocks streamed out four at a time.
        drive(8, 4'h1, 32'h100, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(8, 4'h2, 32'h200, 1'b1, 1'b0);
            else        drive(0, 4'h0, 32'h0, 1'b1, 1'b0);
            chk_slots($sformatf("stream%0d", k), 4,
                      (k < 2) ? 32'h100 + 32'(4*k) : 32'h200 + 32'(4*(k-2)),
                      (k < 2) ? 4'h1 : 4'h2);
            tick();
        end
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("stream_empty", 64'(bus.out_valid), 64'h0);

        // Fill to 32: full only asserts once count exceeds 24.
        for (int b = 0; b < 4; b++) begin
            drive(8, 4'(4 + b), 32'h300 + 32'(16*b), 1'b0, 1'b0);
            tick();
            drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
            check($sformatf("fill%0d_full", b), 64'(bus.full), (b == 3) ? 64'h1 : 64'h0);
        end
        drive(8, 4'hF, 32'h5000, 1'b0, 1'b0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("ignored_full", 64'(bus.full), 64'h1);
        for (int k = 0; k < 8; k++) begin
            drive(0, 4'h0, 32'h0, 1'b1, 1'b0);
            chk_slots($sformatf("drain%0d", k), 4,
                      32'h300 + 32'(16*(k/2)) + 32'(4*(k%2)), 4'(4 + k/2));
            tick();
            drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
            check($sformatf("drain%0d_full", k), 64'(bus.full), (k == 0) ? 64'h1 : 64'h0);
        end
        check("drain_empty", 64'(bus.out_valid), 64'h0);

        // Advance pointers by 9 (to index 28), exercising a partial last read.
        drive(8, 4'h0, 32'h600, 1'b0, 1'b0);
        tick();
        drive(1, 4'h0, 32'h700, 1'b1, 1'b0);
        chk_slots("adv0", 4, 32'h600, 4'h0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b1, 1'b0);
        chk_slots("adv1", 4, 32'h604, 4'h0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b1, 1'b0);
        chk_slots("adv2", 1, 32'h700, 4'h0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("adv_empty", 64'(bus.out_valid), 64'h0);

        // Block straddles entries 28..31 and 0..3.
        drive(8, 4'h9, 32'h800, 1'b0, 1'b0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b1, 1'b0);
        chk_slots("wrap0", 4, 32'h800, 4'h9);
        tick();
        drive(0, 4'h0, 32'h0, 1'b1, 1'b0);
        chk_slots("wrap1", 4, 32'h804, 4'h9);
        tick();
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("wrap_empty", 64'(bus.out_valid), 64'h0);

        // Flush while full, with a competing write and read.
        for (int b = 0; b < 4; b++) begin
            drive(8, 4'(b), 32'hA000 + 32'(16*b), 1'b0, 1'b0);
            tick();
        end
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("preflush_full", 64'(bus.full), 64'h1);
        drive(8, 4'hB, 32'hB000, 1'b1, 1'b1);
        check("flush_same_valid", 64'(bus.out_valid), 64'h0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("flush_next_valid", 64'(bus.out_valid), 64'h0);
        check("flush_next_full", 64'(bus.full), 64'h0);
        tick();
        check("flush_later_valid", 64'(bus.out_valid), 64'h0);
        drive(3, 4'hC, 32'hC000, 1'b0, 1'b0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk_slots("postflush", 3, 32'hC000, 4'hC);
        drive(0, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("postflush_empty", 64'(bus.out_valid), 64'h0);

        // Asynchronous reset mid-traffic with the buffer full.
        for (int b = 0; b < 4; b++) begin
            drive(8, 4'(b), 32'hD000 + 32'(16*b), 1'b0, 1'b0);
            tick();
        end
        drive(0, 4'h0, 32'h0, 1'b0, 1'b0);
        check("prerst_full", 64'(bus.full), 64'h1);
        check("prerst_valid", 64'(bus.out_valid), 64'hF);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'h0);
        check("arst_full", 64'(bus.full), 64'h0);
        check("arst_inst", 64'(bus.out_inst[63:0]), 64'h0);
        check("arst_fsq", 64'(bus.out_fsqIdx), 64'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        check("postrst_valid", 64'(bus.out_valid), 64'h0);
        check("postrst_full", 64'(bus.full), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
